// File: rtl/mc_divider_pkg.sv
// Shared definitions for the multi-cycle divider.
//   div_state_t        : FSM state encoding (IDLE=0, CALC=1, DONE=2), also
//                        exported on the debug state port of mc_divider.
//   DIV_WIDTH_DEFAULT  : default operand/result width.
package mc_divider_pkg;

    localparam int DIV_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/mc_divider_div_step.sv
// One radix-2 restoring division iteration (the div_step datapath).
// Purely combinational.
//   rem_i  in  N  partial remainder (always < b_i)
//   q_i    in  N  dividend bits still to shift in (MSB first) / quotient so far
//   b_i    in  N  divisor magnitude
//   rem_o  out N  next partial remainder
//   q_o    out N  next dividend/quotient register, new quotient bit in [0]
module mc_divider_div_step #(
    parameter int N = 32
) (
    input  logic [N-1:0] rem_i,
    input  logic [N-1:0] q_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] rem_o,
    output logic [N-1:0] q_o
);

    // The shifted remainder needs N+1 bits: rem < b <= 2^N-1, so 2*rem+1
    // can exceed N bits. The compare is done at full width; the difference
    // is always < b and therefore fits back into N bits.
    logic [N:0] shifted;
    logic       ge;

    always_comb begin
        shifted = {rem_i, q_i[N-1]};
        ge      = (shifted >= {1'b0, b_i});
        rem_o   = ge ? (shifted[N-1:0] - b_i) : shifted[N-1:0];
        q_o     = {q_i[N-2:0], ge};
    end

endmodule

// File: rtl/mc_divider.sv
// Multi-cycle iterative integer divider for the EX stage.
// Radix-2 restoring: one quotient bit per cycle, N+1 stall cycles per divide
// (the accepting cycle plus N iterations) followed by one DONE cycle.
// Ports:
//   clk          in   1  clock, all state on posedge
//   reset        in   1  asynchronous active-high reset
//   clear        in   1  synchronous flush, aborts any operation, zeroes result
//   hold_in      in   1  downstream stall, keeps DONE and result frozen
//   start        in   1  divide instruction present in EX
//   is_signed    in   1  1: two's-complement operands
//   want_rem     in   1  1: return remainder, 0: quotient
//   dividend     in   N  operand a
//   divisor      in   N  operand b
//   stall        out  1  start & ~done, to the upstream pipeline hold inputs
//   busy         out  1  state != IDLE
//   done         out  1  state == DONE
//   result       out  N  quotient/remainder, valid while done=1
//   dbg_state_o  out  2  current FSM state
//
// Handshake: the EX stage raises start and keeps it (and the operands) steady
// while stall=1. Operands are captured only on the IDLE->CALC edge. stall
// drops in the cycle where done=1, so the pipeline advances on that edge; if
// hold_in=1 the divider stays in DONE (ignoring start) until hold_in drops.
module mc_divider
    import mc_divider_pkg::*;
#(
    parameter int N = DIV_WIDTH_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         hold_in,
    input  logic         start,
    input  logic         is_signed,
    input  logic         want_rem,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         stall,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output div_state_t   dbg_state_o
);

    localparam int            CW            = $clog2(N);
    localparam logic [CW-1:0] CNT_INIT      = CW'(N - 1);
    localparam logic [N-1:0]  DIV0_QUOTIENT = '1;

    div_state_t    state_q,    state_d;
    logic [CW-1:0] cnt_q,      cnt_d;
    logic [N-1:0]  rem_q,      rem_d;
    logic [N-1:0]  q_q,        q_d;
    logic [N-1:0]  b_q,        b_d;
    logic          want_rem_q, want_rem_d;
    logic          qsign_q,    qsign_d;
    logic          rsign_q,    rsign_d;
    logic          div0_q,     div0_d;
    logic [N-1:0]  result_q,   result_d;

    logic [N-1:0]  a_mag;
    logic [N-1:0]  b_mag;
    logic [N-1:0]  step_rem;
    logic [N-1:0]  step_q;
    logic [N-1:0]  quot_fixed;
    logic [N-1:0]  rem_fixed;

    mc_divider_div_step #(
        .N (N)
    ) u_step (
        .rem_i (rem_q),
        .q_i   (q_q),
        .b_i   (b_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    // Magnitudes wrap modulo 2^N: |-2^(N-1)| = 2^(N-1) still fits unsigned,
    // which is what makes the signed-overflow case come out right.
    assign a_mag = (is_signed && dividend[N-1]) ? -dividend : dividend;
    assign b_mag = (is_signed && divisor[N-1])  ? -divisor  : divisor;

    // qsign/rsign are only ever set for signed operations. Divide by zero
    // forces the all-ones quotient; the remainder path already returns the
    // original dividend bits (|a| with the sign of a restored).
    assign quot_fixed = div0_q  ? DIV0_QUOTIENT
                      : qsign_q ? -step_q : step_q;
    assign rem_fixed  = rsign_q ? -step_rem : step_rem;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            q_q        <= '0;
            b_q        <= '0;
            want_rem_q <= 1'b0;
            qsign_q    <= 1'b0;
            rsign_q    <= 1'b0;
            div0_q     <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            q_q        <= q_d;
            b_q        <= b_d;
            want_rem_q <= want_rem_d;
            qsign_q    <= qsign_d;
            rsign_q    <= rsign_d;
            div0_q     <= div0_d;
            result_q   <= result_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        q_d        = q_q;
        b_d        = b_q;
        want_rem_d = want_rem_q;
        qsign_d    = qsign_q;
        rsign_d    = rsign_q;
        div0_d     = div0_q;
        result_d   = result_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    want_rem_d = want_rem;
                    qsign_d    = is_signed & (dividend[N-1] ^ divisor[N-1]);
                    rsign_d    = is_signed & dividend[N-1];
                    div0_d     = (divisor == '0);
                    q_d        = a_mag;
                    b_d        = b_mag;
                    rem_d      = '0;
                    cnt_d      = CNT_INIT;
                    state_d    = ST_CALC;
                end
            end
            ST_CALC: begin
                rem_d = step_rem;
                q_d   = step_q;
                if (cnt_q == '0) begin
                    // Final iteration: sign fix uses this cycle's step output.
                    result_d = want_rem_q ? rem_fixed : quot_fixed;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (!hold_in) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flush wins over everything the FSM decided this cycle and wipes
        // all operation state so an aborted divide leaves nothing behind.
        if (clear) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            rem_d      = '0;
            q_d        = '0;
            b_d        = '0;
            want_rem_d = 1'b0;
            qsign_d    = 1'b0;
            rsign_d    = 1'b0;
            div0_d     = 1'b0;
            result_d   = '0;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign stall       = start & ~done;
    assign result      = result_q;
    assign dbg_state_o = state_q;

endmodule
